// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SECDED burst SRAM controller.
package sram_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SLEEP,
      ST_WAKE,
      ST_WR_SETUP,
      ST_WR_STROBE,
      ST_RD_SETUP,
      ST_RD_CAPTURE
   } state_e;

   localparam logic [7:0] KEY_DEFAULT = 8'hA5;

   // Hamming bits P (smallest P with 2**P >= data_w+P+1) plus one overall parity bit.
   function automatic int ecc_width(input int data_w);
      int p;
      p = 0;
      for (int i = 7; i >= 1; i--) begin
         if ((1 << i) >= data_w + i + 1) p = i;
      end
      return p + 1;
   endfunction

endpackage

// File: rtl/sram_secded_codec.sv
// Combinational SECDED encoder (write side) and decoder/corrector (read side).
module sram_secded_codec
   import sram_ctrl_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0]                   enc_data_i,
   output logic [DATA_W+ecc_width(DATA_W)-1:0] enc_word_o,
   input  logic [DATA_W+ecc_width(DATA_W)-1:0] dec_word_i,
   output logic [DATA_W-1:0]                   dec_data_o,
   output logic                                dec_corr_o,
   output logic                                dec_uncorr_o
);

   localparam int ECC_W = ecc_width(DATA_W);
   localparam int P     = ECC_W - 1;
   localparam int N     = DATA_W + P;

   // Data bits occupy the non-power-of-two Hamming positions 1..N in ascending order.
   function automatic logic [N:1] scatter(input logic [DATA_W-1:0] d);
      logic [N:1] cw;
      int         j;
      cw = '0;
      j  = 0;
      for (int pos = 1; pos <= N; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            cw[pos] = d[j];
            j++;
         end
      end
      return cw;
   endfunction

   function automatic logic [DATA_W-1:0] gather(input logic [N:1] cw);
      logic [DATA_W-1:0] d;
      int                j;
      d = '0;
      j = 0;
      for (int pos = 1; pos <= N; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            d[j] = cw[pos];
            j++;
         end
      end
      return d;
   endfunction

   function automatic logic [P-1:0] syndrome(input logic [N:1] cw);
      logic [P-1:0] s;
      s = '0;
      for (int pos = 1; pos <= N; pos++) begin
         for (int b = 0; b < P; b++) begin
            if (((pos >> b) & 1) == 1) s[b] = s[b] ^ cw[pos];
         end
      end
      return s;
   endfunction

   logic [N:1]   enc_cw;
   logic [P-1:0] enc_ham;

   always_comb begin
      enc_cw     = scatter(enc_data_i);
      enc_ham    = syndrome(enc_cw);
      enc_word_o = {^{enc_ham, enc_data_i}, enc_ham, enc_data_i};
   end

   logic [N:1]   dec_cw;
   logic [P-1:0] dec_syn;
   logic         dec_par_bad;

   always_comb begin
      dec_cw = scatter(dec_word_i[DATA_W-1:0]);
      for (int b = 0; b < P; b++) dec_cw[1 << b] = dec_word_i[DATA_W + b];
      dec_syn      = syndrome(dec_cw);
      dec_par_bad  = ^dec_word_i;
      dec_corr_o   = 1'b0;
      dec_uncorr_o = 1'b0;
      // Syndrome 0 with bad parity means the overall parity bit itself flipped.
      if (dec_par_bad) begin
         if (int'(dec_syn) <= N) begin
            dec_corr_o = 1'b1;
            if (dec_syn != '0) dec_cw[dec_syn] = ~dec_cw[dec_syn];
         end else begin
            dec_uncorr_o = 1'b1;
         end
      end else if (dec_syn != '0) begin
         dec_uncorr_o = 1'b1;
      end
      dec_data_o = dec_uncorr_o ? dec_word_i[DATA_W-1:0] : gather(dec_cw);
   end

endmodule

// File: rtl/sram_secded_burst_ctrl.sv
// Key-gated burst controller for an external async SRAM with per-word SECDED and idle sleep.
module sram_secded_burst_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int         DATA_W   = 8,
   parameter int         ADDR_W   = 16,
   parameter int         LEN_W    = 8,
   parameter int         IDLE_CYC = 64,
   parameter logic [7:0] KEY      = KEY_DEFAULT
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                req_valid,
   output logic                                req_ready,
   input  logic                                req_we,
   input  logic [ADDR_W-1:0]                   req_addr,
   input  logic [LEN_W-1:0]                    req_len,
   input  logic [7:0]                          req_key,
   input  logic [DATA_W-1:0]                   wr_data,
   input  logic                                wr_valid,
   output logic                                wr_ready,
   output logic [DATA_W-1:0]                   rd_data,
   output logic                                rd_valid,
   output logic                                rd_last,
   output logic                                access_denied,
   output logic                                corr_err,
   output logic                                uncorr_err,
   output logic                                power_save,
   output logic                                sram_cs_n,
   output logic                                sram_we_n,
   output logic                                sram_oe_n,
   output logic [ADDR_W-1:0]                   sram_addr,
   output logic [DATA_W+ecc_width(DATA_W)-1:0] sram_wdata,
   output logic                                sram_dq_oe,
   input  logic [DATA_W+ecc_width(DATA_W)-1:0] sram_rdata
);

   localparam int                CODE_W    = DATA_W + ecc_width(DATA_W);
   localparam int                IDLE_W    = $clog2(IDLE_CYC + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    beats_q, beats_d;
   logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic [CODE_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic                rd_last_q, rd_last_d;
   logic                corr_q, corr_d;
   logic                uncorr_q, uncorr_d;
   logic                denied_q, denied_d;
   logic                cs_n_q, cs_n_d;
   logic                we_n_q, we_n_d;
   logic                oe_n_q, oe_n_d;
   logic                dq_oe_q, dq_oe_d;
   logic                req_ready_q, req_ready_d;
   logic                wr_ready_q, wr_ready_d;
   logic                power_save_q, power_save_d;

   logic [CODE_W-1:0]   enc_word;
   logic [DATA_W-1:0]   dec_data;
   logic                dec_corr;
   logic                dec_uncorr;

   sram_secded_codec #(.DATA_W(DATA_W)) u_codec (
      .enc_data_i   (wr_data),
      .enc_word_o   (enc_word),
      .dec_word_i   (sram_rdata),
      .dec_data_o   (dec_data),
      .dec_corr_o   (dec_corr),
      .dec_uncorr_o (dec_uncorr)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      beats_d    = beats_q;
      idle_cnt_d = '0;
      wdata_d    = wdata_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      corr_d     = 1'b0;
      uncorr_d   = 1'b0;
      denied_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_ready_q) begin
                  if (req_key == KEY) begin
                     addr_d  = req_addr;
                     beats_d = req_len;
                     state_d = req_we ? ST_WR_SETUP : ST_RD_SETUP;
                  end else begin
                     denied_d = 1'b1;
                  end
               end
            end else if (idle_cnt_q == IDLE_LAST) begin
               state_d = ST_SLEEP;
            end else begin
               idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
         end
         ST_SLEEP: begin
            if (req_valid) state_d = ST_WAKE;
         end
         ST_WAKE: state_d = ST_IDLE;
         ST_WR_SETUP: begin
            if (wr_valid) begin
               wdata_d = enc_word;
               state_d = ST_WR_STROBE;
            end
         end
         ST_WR_STROBE: begin
            addr_d  = addr_q + ADDR_W'(1);
            beats_d = beats_q - LEN_W'(1);
            state_d = (beats_q == '0) ? ST_IDLE : ST_WR_SETUP;
         end
         ST_RD_SETUP: state_d = ST_RD_CAPTURE;
         ST_RD_CAPTURE: begin
            rd_data_d  = dec_data;
            rd_valid_d = 1'b1;
            rd_last_d  = (beats_q == '0);
            corr_d     = dec_corr;
            uncorr_d   = dec_uncorr;
            addr_d     = addr_q + ADDR_W'(1);
            beats_d    = beats_q - LEN_W'(1);
            state_d    = (beats_q == '0) ? ST_IDLE : ST_RD_SETUP;
         end
         default: state_d = ST_IDLE;
      endcase

      // Strobes decode from the next state so they stay aligned with the state register;
      // dq_oe and oe_n come from disjoint state sets and can never overlap.
      cs_n_d       = !(state_d inside {ST_WR_SETUP, ST_WR_STROBE, ST_RD_SETUP, ST_RD_CAPTURE});
      we_n_d       = (state_d != ST_WR_STROBE);
      oe_n_d       = !(state_d inside {ST_RD_SETUP, ST_RD_CAPTURE});
      dq_oe_d      = (state_d inside {ST_WR_SETUP, ST_WR_STROBE});
      req_ready_d  = (state_d == ST_IDLE);
      wr_ready_d   = (state_d == ST_WR_SETUP);
      power_save_d = (state_d == ST_SLEEP);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         beats_q      <= '0;
         idle_cnt_q   <= '0;
         wdata_q      <= '0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         rd_last_q    <= 1'b0;
         corr_q       <= 1'b0;
         uncorr_q     <= 1'b0;
         denied_q     <= 1'b0;
         cs_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         dq_oe_q      <= 1'b0;
         req_ready_q  <= 1'b0;
         wr_ready_q   <= 1'b0;
         power_save_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         beats_q      <= beats_d;
         idle_cnt_q   <= idle_cnt_d;
         wdata_q      <= wdata_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
         rd_last_q    <= rd_last_d;
         corr_q       <= corr_d;
         uncorr_q     <= uncorr_d;
         denied_q     <= denied_d;
         cs_n_q       <= cs_n_d;
         we_n_q       <= we_n_d;
         oe_n_q       <= oe_n_d;
         dq_oe_q      <= dq_oe_d;
         req_ready_q  <= req_ready_d;
         wr_ready_q   <= wr_ready_d;
         power_save_q <= power_save_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign wr_ready      = wr_ready_q;
   assign rd_data       = rd_data_q;
   assign rd_valid      = rd_valid_q;
   assign rd_last       = rd_last_q;
   assign access_denied = denied_q;
   assign corr_err      = corr_q;
   assign uncorr_err    = uncorr_q;
   assign power_save    = power_save_q;
   assign sram_cs_n     = cs_n_q;
   assign sram_we_n     = we_n_q;
   assign sram_oe_n     = oe_n_q;
   assign sram_addr     = addr_q;
   assign sram_wdata    = wdata_q;
   assign sram_dq_oe    = dq_oe_q;

endmodule

// File: tb/tb_sram_secded_burst_ctrl.sv
// Self-checking bench: behavioural SRAM with fault injection plus a data-level reference memory.
`timescale 1ns/1ps
module tb_sram_secded_burst_ctrl;
   import sram_ctrl_pkg::*;

   localparam int         DATA_W   = 8;
   localparam int         ADDR_W   = 16;
   localparam int         LEN_W    = 8;
   localparam int         IDLE_CYC = 64;
   localparam logic [7:0] KEY      = 8'hA5;
   localparam int         CODE_W   = DATA_W + ecc_width(DATA_W);
   localparam int         DEPTH    = 1 << ADDR_W;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                req_valid, req_ready, req_we;
   logic [ADDR_W-1:0]   req_addr;
   logic [LEN_W-1:0]    req_len;
   logic [7:0]          req_key;
   logic [DATA_W-1:0]   wr_data;
   logic                wr_valid, wr_ready;
   logic [DATA_W-1:0]   rd_data;
   logic                rd_valid, rd_last, access_denied, corr_err, uncorr_err, power_save;
   logic                sram_cs_n, sram_we_n, sram_oe_n, sram_dq_oe;
   logic [ADDR_W-1:0]   sram_addr;
   logic [CODE_W-1:0]   sram_wdata, sram_rdata;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   sram_secded_burst_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .IDLE_CYC(IDLE_CYC), .KEY(KEY)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_len(req_len), .req_key(req_key),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
      .access_denied(access_denied), .corr_err(corr_err), .uncorr_err(uncorr_err),
      .power_save(power_save),
      .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_dq_oe(sram_dq_oe),
      .sram_rdata(sram_rdata)
   );

   // Behavioural async SRAM: stores whole code words; one injectable fault mask on read.
   logic [CODE_W-1:0] mem [0:DEPTH-1];
   logic [ADDR_W-1:0] inj_addr;
   logic [CODE_W-1:0] inj_mask;
   logic [ADDR_W-1:0] wr_log [0:255];
   int                wr_log_n   = 0;
   int                we_low_cnt = 0;
   int                viol_cnt   = 0;

   assign sram_rdata = mem[sram_addr] ^ ((sram_addr == inj_addr) ? inj_mask : '0);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!sram_we_n) we_low_cnt <= we_low_cnt + 1;
      if (!sram_cs_n && !sram_we_n) begin
         mem[sram_addr]           <= sram_wdata;
         wr_log[wr_log_n % 256]   <= sram_addr;
         wr_log_n                 <= wr_log_n + 1;
      end
      if (sram_dq_oe && !sram_oe_n) viol_cnt <= viol_cnt + 1;
   end

   // Reference model: data content per address, updated only by accepted (key-matching) writes.
   logic [DATA_W-1:0] ref_mem [int];
   logic [DATA_W-1:0] wbuf        [0:255];
   logic [DATA_W-1:0] rbuf_data   [0:255];
   logic              rbuf_last   [0:255];
   logic              rbuf_corr   [0:255];
   logic              rbuf_uncorr [0:255];
   int                rcount;

   task automatic do_request(input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [LEN_W-1:0] len, input logic [7:0] key,
                             output logic denied, output int acc_cyc);
      int n;
      n = 0;
      req_we = we; req_addr = addr; req_len = len; req_key = key; req_valid = 1'b1;
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL req_timeout: req_ready=%0b required 1", req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      denied    = access_denied;
      acc_cyc   = cyc;
   endtask

   task automatic write_burst(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                              input logic [7:0] key, output logic denied);
      int                acc;
      int                n;
      logic [ADDR_W-1:0] a;
      do_request(1'b1, addr, len, key, denied, acc);
      if (key == KEY) begin
         for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            wr_data = wbuf[i]; wr_valid = 1'b1;
            while (!wr_ready && n < 50) begin @(negedge clk); n++; end
            if (!wr_ready) begin
               checks++; errors++;
               $display("FAIL wr_ready_timeout: beat=%0d wr_ready=%0b required 1", i, wr_ready);
            end
            @(posedge clk);
            @(negedge clk);
            wr_valid = 1'b0;
            a = addr + ADDR_W'(i);
            ref_mem[int'(a)] = wbuf[i];
         end
         n = 0;
         while (!req_ready && n < 50) begin @(negedge clk); n++; end
      end
   endtask

   task automatic read_burst(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                             output int lat);
      logic d;
      int   acc;
      int   n;
      do_request(1'b0, addr, len, KEY, d, acc);
      rcount = 0; lat = -1; n = 0;
      while (rcount <= int'(len) && n < 8 * (int'(len) + 1) + 20) begin
         if (rd_valid) begin
            rbuf_data[rcount]   = rd_data;
            rbuf_last[rcount]   = rd_last;
            rbuf_corr[rcount]   = corr_err;
            rbuf_uncorr[rcount] = uncorr_err;
            if (rcount == 0) lat = cyc - acc;
            rcount++;
         end
         if (rcount <= int'(len)) begin @(negedge clk); n++; end
      end
      checks++;
      if (rcount != int'(len) + 1) begin
         errors++;
         $display("FAIL rd_beats: got %0d beats required %0d", rcount, int'(len) + 1);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks += 8;
      if ({sram_cs_n, sram_we_n, sram_oe_n} !== 3'b111) begin errors++;
         $display("FAIL reset_strobes: got %b required 111", {sram_cs_n, sram_we_n, sram_oe_n}); end
      if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_dq_oe: got %b required 0", sram_dq_oe); end
      if (sram_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h required 0", sram_addr); end
      if (sram_wdata !== '0) begin errors++; $display("FAIL reset_wdata: got %h required 0", sram_wdata); end
      if ({req_ready, wr_ready} !== 2'b00) begin errors++;
         $display("FAIL reset_ready: got %b required 00", {req_ready, wr_ready}); end
      if ({rd_valid, rd_last, access_denied, corr_err, uncorr_err} !== 5'b0) begin errors++;
         $display("FAIL reset_pulses: got %b required 00000", {rd_valid, rd_last, access_denied, corr_err, uncorr_err}); end
      if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h required 0", rd_data); end
      if (power_save !== 1'b0) begin errors++; $display("FAIL reset_power_save: got %b required 0", power_save); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", req_ready); end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      logic d;
      int   lat;
      wbuf[0] = 8'hAA;
      write_burst(16'h0001, 0, KEY, d);
      checks++;
      if (mem[1][DATA_W-1:0] !== 8'hAA) begin errors++;
         $display("FAIL basic_stored: got %h required aa", mem[1][DATA_W-1:0]); end
      read_burst(16'h0001, 0, lat);
      checks += 4;
      if (rbuf_data[0] !== 8'hAA) begin errors++; $display("FAIL basic_rd_data: got %h required aa", rbuf_data[0]); end
      if (rbuf_last[0] !== 1'b1) begin errors++; $display("FAIL basic_rd_last: got %b required 1", rbuf_last[0]); end
      if ({rbuf_corr[0], rbuf_uncorr[0]} !== 2'b00) begin errors++;
         $display("FAIL basic_flags: got %b required 00", {rbuf_corr[0], rbuf_uncorr[0]}); end
      if (lat != 2) begin errors++; $display("FAIL basic_latency: got %0d required 2", lat); end
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_rd_pulse: got %b required 0", rd_valid); end
      $display("test_basic: wrote/read aa @0001 data=%h lat=%0d", rbuf_data[0], lat);
   endtask

   task automatic test_denied();
      logic d;
      int   lat;
      int   we_before;
      wbuf[0] = 8'h5C;
      write_burst(16'h0004, 0, KEY, d);
      we_before = we_low_cnt;
      wbuf[0] = 8'h33;
      write_burst(16'h0004, 0, 8'hFF, d);
      checks++;
      if (d !== 1'b1) begin errors++; $display("FAIL denied_pulse: got %b required 1", d); end
      @(negedge clk);
      checks++;
      if (access_denied !== 1'b0) begin errors++; $display("FAIL denied_one_cycle: got %b required 0", access_denied); end
      repeat (4) @(negedge clk);
      checks += 2;
      if (we_low_cnt != we_before) begin errors++;
         $display("FAIL denied_no_write: we_n low cycles %0d required %0d", we_low_cnt, we_before); end
      if (req_ready !== 1'b1) begin errors++; $display("FAIL denied_idle: req_ready=%b required 1", req_ready); end
      read_burst(16'h0004, 0, lat);
      checks++;
      if (rbuf_data[0] !== ref_mem[4]) begin errors++;
         $display("FAIL denied_unchanged: got %h required %h", rbuf_data[0], ref_mem[4]); end
      $display("test_denied: read @0004 data=%h", rbuf_data[0]);
   endtask

   task automatic test_wrap_burst();
      logic              d;
      int                lat;
      int                log_start;
      logic [ADDR_W-1:0] a;
      wbuf[0] = 8'hCC; wbuf[1] = 8'hDD; wbuf[2] = 8'hEE; wbuf[3] = 8'hFF;
      log_start = wr_log_n;
      write_burst(16'hFFFE, 3, KEY, d);
      checks++;
      if (wr_log_n - log_start != 4) begin errors++;
         $display("FAIL wrap_write_count: got %0d required 4", wr_log_n - log_start); end
      for (int i = 0; i < 4; i++) begin
         a = 16'hFFFE + ADDR_W'(i);
         checks++;
         if (wr_log[(log_start + i) % 256] !== a) begin errors++;
            $display("FAIL wrap_write_addr: beat %0d got %h required %h", i, wr_log[(log_start + i) % 256], a); end
      end
      read_burst(16'hFFFE, 3, lat);
      for (int i = 0; i < 4; i++) begin
         a = 16'hFFFE + ADDR_W'(i);
         checks += 2;
         if (rbuf_data[i] !== ref_mem[int'(a)]) begin errors++;
            $display("FAIL wrap_rd_data: beat %0d got %h required %h", i, rbuf_data[i], ref_mem[int'(a)]); end
         if (rbuf_last[i] !== (i == 3)) begin errors++;
            $display("FAIL wrap_rd_last: beat %0d got %b required %b", i, rbuf_last[i], (i == 3)); end
         $display("test_wrap_burst: beat %0d addr %h data %h last %b", i, a, rbuf_data[i], rbuf_last[i]);
      end
   endtask

   task automatic test_ecc_inject();
      int                lat;
      logic [ADDR_W-1:0] a;
      logic [CODE_W-1:0] m;
      logic [DATA_W-1:0] exp_d;
      int                b1, b2;
      logic [ADDR_W-1:0] pool [0:4];
      pool[0] = 16'h0001; pool[1] = 16'h0004; pool[2] = 16'hFFFE; pool[3] = 16'hFFFF; pool[4] = 16'h0000;
      for (int t = 0; t < 12; t++) begin
         if (t == 0) begin a = 16'h0001; b1 = 3; b2 = -1; end
         else if (t == 1) begin a = 16'h0001; b1 = 3; b2 = 5; end
         else begin
            a  = pool[$urandom_range(4, 0)];
            b1 = $urandom_range(CODE_W - 1, 0);
            b2 = -1;
            if (t >= 7) begin
               b2 = $urandom_range(CODE_W - 1, 0);
               if (b2 == b1) b2 = (b1 + 1) % CODE_W;
            end
         end
         m = '0;
         m[b1] = 1'b1;
         if (b2 >= 0) m[b2] = 1'b1;
         inj_addr = a; inj_mask = m;
         read_burst(a, 0, lat);
         exp_d = ref_mem[int'(a)];
         if (b2 >= 0) exp_d = exp_d ^ m[DATA_W-1:0];
         checks += 2;
         if (rbuf_data[0] !== exp_d) begin errors++;
            $display("FAIL ecc_data: addr %h mask %h got %h required %h", a, m, rbuf_data[0], exp_d); end
         if ({rbuf_corr[0], rbuf_uncorr[0]} !== ((b2 >= 0) ? 2'b01 : 2'b10)) begin errors++;
            $display("FAIL ecc_flags: addr %h mask %h got corr=%b uncorr=%b required %b", a, m,
                     rbuf_corr[0], rbuf_uncorr[0], ((b2 >= 0) ? 2'b01 : 2'b10)); end
         $display("test_ecc_inject: addr %h mask %h data %h corr %b uncorr %b", a, m, rbuf_data[0],
                  rbuf_corr[0], rbuf_uncorr[0]);
      end
      inj_mask = '0;
   endtask

   task automatic test_random_bursts();
      logic              d;
      int                lat;
      logic [ADDR_W-1:0] base, a;
      logic [LEN_W-1:0]  len;
      for (int t = 0; t < 6; t++) begin
         base = ADDR_W'($urandom_range(DEPTH - 1, 0));
         len  = LEN_W'($urandom_range(7, 0));
         for (int i = 0; i <= int'(len); i++) wbuf[i] = DATA_W'($urandom);
         write_burst(base, len, KEY, d);
         read_burst(base, len, lat);
         for (int i = 0; i <= int'(len); i++) begin
            a = base + ADDR_W'(i);
            checks += 3;
            if (mem[a][DATA_W-1:0] !== ref_mem[int'(a)]) begin errors++;
               $display("FAIL rand_stored: addr %h got %h required %h", a, mem[a][DATA_W-1:0], ref_mem[int'(a)]); end
            if (rbuf_data[i] !== ref_mem[int'(a)]) begin errors++;
               $display("FAIL rand_rd_data: addr %h got %h required %h", a, rbuf_data[i], ref_mem[int'(a)]); end
            if ({rbuf_last[i], rbuf_corr[i], rbuf_uncorr[i]} !== {(i == int'(len)), 2'b00}) begin errors++;
               $display("FAIL rand_flags: addr %h got %b required %b", a,
                        {rbuf_last[i], rbuf_corr[i], rbuf_uncorr[i]}, {(i == int'(len)), 2'b00}); end
         end
         $display("test_random_bursts: base %h len %0d beats %0d", base, len, rcount);
      end
   endtask

   task automatic test_sleep();
      int lat;
      read_burst(16'h0001, 0, lat);
      repeat (IDLE_CYC - 2) @(negedge clk);
      checks++;
      if (power_save !== 1'b0) begin errors++; $display("FAIL sleep_early: power_save=%b required 0", power_save); end
      repeat (3) @(negedge clk);
      checks += 3;
      if (power_save !== 1'b1) begin errors++; $display("FAIL sleep_enter: power_save=%b required 1", power_save); end
      if (sram_cs_n !== 1'b1) begin errors++; $display("FAIL sleep_cs_n: got %b required 1", sram_cs_n); end
      if (req_ready !== 1'b0) begin errors++; $display("FAIL sleep_ready: got %b required 0", req_ready); end
      read_burst(16'hFFFE, 0, lat);
      checks += 2;
      if (rbuf_data[0] !== ref_mem[16'hFFFE]) begin errors++;
         $display("FAIL sleep_wake_data: got %h required %h", rbuf_data[0], ref_mem[16'hFFFE]); end
      if (power_save !== 1'b0) begin errors++; $display("FAIL sleep_wake: power_save=%b required 0", power_save); end
      $display("test_sleep: woke and read %h", rbuf_data[0]);
   endtask

   task automatic test_reset_mid_burst();
      logic d;
      int   acc;
      int   n;
      for (int i = 0; i < 4; i++) wbuf[i] = DATA_W'($urandom);
      do_request(1'b1, 16'h0100, 3, KEY, d, acc);
      n = 0;
      wr_data = wbuf[0]; wr_valid = 1'b1;
      while (!wr_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      wr_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      checks += 3;
      if ({sram_cs_n, sram_we_n, sram_oe_n} !== 3'b111) begin errors++;
         $display("FAIL midrst_strobes: got %b required 111", {sram_cs_n, sram_we_n, sram_oe_n}); end
      if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL midrst_dq_oe: got %b required 0", sram_dq_oe); end
      if ({req_ready, wr_ready} !== 2'b00) begin errors++;
         $display("FAIL midrst_ready: got %b required 00", {req_ready, wr_ready}); end
      rst_n = 1'b1;
      @(negedge clk);
      checks += 2;
      if (sram_cs_n !== 1'b1) begin errors++; $display("FAIL midrst_no_strobe: cs_n=%b required 1", sram_cs_n); end
      if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: req_ready=%b required 1", req_ready); end
      $display("test_reset_mid_burst: cs_n %b req_ready %b", sram_cs_n, req_ready);
   endtask

   task automatic test_invariants();
      checks++;
      if (viol_cnt != 0) begin errors++;
         $display("FAIL dq_oe_oe_n_overlap: got %0d cycles required 0", viol_cnt); end
      $display("test_invariants: overlap cycles %0d", viol_cnt);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0; req_key = '0;
      wr_data = '0; wr_valid = 1'b0; inj_addr = '0; inj_mask = '0;
      test_reset();
      test_basic();
      test_denied();
      test_wrap_burst();
      test_ecc_inject();
      test_random_bursts();
      test_sleep();
      test_reset_mid_burst();
      test_invariants();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
